// File: rtl/smpl_queue.sv
// rtl/smpl_queue.sv - circular stereo sample buffer replaying the TAPS newest pairs oldest-first
module smpl_queue #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int TAPS  = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rht_smpl,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rht_out,
  output logic        primed,
  output logic        overrun
);

  localparam int            FW      = AW + 1;
  localparam logic [FW-1:0] TAPS_F  = FW'(TAPS);
  localparam logic [AW-1:0] TAPS_M1 = AW'(TAPS - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] new_ptr, rd_ptr, rd_cnt;
  logic [FW-1:0] fill_cnt, fill_nxt;
  logic          start, last;

  always_comb begin
    fill_nxt  = (fill_cnt == TAPS_F) ? TAPS_F : fill_cnt + FW'(1);
    start     = (state == IDLE) && wrt_smpl && (fill_nxt == TAPS_F);
    last      = (state == READ) && (rd_cnt == TAPS_M1);
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Storage is deliberately unreset; writes land even during a readout.
  always_ff @(posedge clk) begin
    if (wrt_smpl) mem[new_ptr] <= {lft_smpl, rht_smpl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr    <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      fill_cnt   <= '0;
      sequencing <= 1'b0;
      lft_out    <= '0;
      rht_out    <= '0;
      primed     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sequencing <= (state == READ);
      if (wrt_smpl) begin
        new_ptr  <= new_ptr + AW'(1);
        fill_cnt <= fill_nxt;
        primed   <= (fill_nxt == TAPS_F);
        if (state == READ) overrun <= 1'b1;
      end
      // Oldest pair of the window sits TAPS-1 slots behind the one being written now.
      if (start) begin
        rd_ptr <= new_ptr - TAPS_M1;
        rd_cnt <= '0;
      end else if (state == READ) begin
        {lft_out, rht_out} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
        rd_cnt <= rd_cnt + AW'(1);
      end
    end
  end

endmodule
